// File: rtl/bin_pkg.sv
// Shared constants and width helpers for the 2x2 binning stage.
package bin_pkg;

  localparam int unsigned DEF_PIXEL_BIT_WIDTH = 12;
  localparam int unsigned DEF_IN_ROWS         = 20;
  localparam int unsigned DEF_IN_COLS         = 20;

  // Pair sum and quad sum widths
  function automatic int unsigned sum2_w(input int unsigned pw);
    return pw + 1;
  endfunction

  function automatic int unsigned sum4_w(input int unsigned pw);
    return pw + 2;
  endfunction

  // Counter/address width, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bin_line_buffer.sv
// Half-line store of horizontal pair sums from the even row of each block pair.
module bin_line_buffer
  import bin_pkg::*;
#(
  parameter int unsigned DEPTH  = 10,
  parameter int unsigned DATA_W = 13,
  localparam int unsigned ADDR_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Not reset: every entry is written on the even row before the odd row reads it
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/bin2x2_filter.sv
// 2x2 binning of a raster pixel stream with valid/ready output backpressure.
// Optional BIN2X2_ROUND_EN selects round-half-up instead of truncation.
module bin2x2_filter
  import bin_pkg::*;
#(
  parameter int unsigned PIXEL_BIT_WIDTH = DEF_PIXEL_BIT_WIDTH,
  parameter int unsigned IN_ROWS         = DEF_IN_ROWS,
  parameter int unsigned IN_COLS         = DEF_IN_COLS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int unsigned PW     = PIXEL_BIT_WIDTH;
  localparam int unsigned SUM2_W = sum2_w(PIXEL_BIT_WIDTH);
  localparam int unsigned SUM4_W = sum4_w(PIXEL_BIT_WIDTH);
  localparam int unsigned COL_W  = cnt_w(IN_COLS);
  localparam int unsigned ROW_W  = cnt_w(IN_ROWS);
  localparam int unsigned LB_D   = IN_COLS / 2;
  localparam int unsigned ADDR_W = cnt_w(LB_D);

  if ((IN_ROWS % 2) != 0 || (IN_COLS % 2) != 0 || IN_ROWS < 2 || IN_COLS < 2) begin : g_bad_size
    $error("bin2x2_filter: IN_ROWS and IN_COLS must be even and >= 2");
  end

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [PW-1:0]     hold_q, hold_d;
  logic [PW-1:0]     pixel_out_q, pixel_out_d;
  logic              out_valid_q, out_valid_d;

  logic              accept_c;
  logic              lb_we;
  logic [ADDR_W-1:0] lb_addr;
  logic [SUM2_W-1:0] lb_wdata;
  logic [SUM2_W-1:0] lb_rdata;
  logic [SUM4_W-1:0] sum4;
  logic [SUM4_W-1:0] sum4_adj;

  assign in_ready = !(out_valid_q && !out_ready);
  assign accept_c = in_valid && in_ready;
  assign lb_addr  = ADDR_W'(col_q >> 1);

  bin_line_buffer #(
    .DEPTH (LB_D),
    .DATA_W(SUM2_W)
  ) u_line_buffer (
    .clk  (clk),
    .we   (lb_we),
    .waddr(lb_addr),
    .wdata(lb_wdata),
    .raddr(lb_addr),
    .rdata(lb_rdata)
  );

  // Counters, hold register, line buffer write and output register next-state
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    pixel_out_d = pixel_out_q;
    out_valid_d = out_valid_q && !out_ready;
    lb_we       = 1'b0;
    lb_wdata    = SUM2_W'(hold_q) + SUM2_W'(pixel_in);
    sum4        = SUM4_W'(lb_rdata) + SUM4_W'(hold_q) + SUM4_W'(pixel_in);
`ifdef BIN2X2_ROUND_EN
    sum4_adj    = sum4 + SUM4_W'(2);
`else
    sum4_adj    = sum4;
`endif

    if (accept_c) begin
      if (col_q == COL_W'(IN_COLS - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IN_ROWS - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end

      if (!col_q[0]) begin
        hold_d = pixel_in;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        pixel_out_d = PW'(sum4_adj >> 2);
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      pixel_out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      pixel_out_q <= pixel_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign pixel_out = pixel_out_q;
  assign out_valid = out_valid_q;

endmodule
